multicycle_ctrl: RTL and testbench

Multicycle control FSM for the RV32I core. Sequences the shared datapath (PC, instruction register, register file, ALU, immediate generator, unified memory port) through fetch/decode/execute/memory/writeback, one instruction at a time. Drives the immediate-type select consumed by the immediate generator, evaluates branch conditions from ALU flags, and handshakes with memory. Sits between the instruction register and all datapath write enables and muxes.

---
 rtl/cpu_ctrl_pkg.sv | 61 ++++++
 rtl/branch_cond.sv | 33 +++
 rtl/multicycle_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// ============================================================================
// Module : cpu_ctrl_pkg
// Brief  : Shared encodings for the RV32I multicycle controller and datapath.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } state_t;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_U = 3'd3;
    localparam logic [2:0] IMM_J = 3'd4;

    localparam logic [1:0] SRCA_RS1  = 2'd0;
    localparam logic [1:0] SRCA_PC   = 2'd1;
    localparam logic [1:0] SRCA_ZERO = 2'd2;

    localparam logic [1:0] SRCB_RS2  = 2'd0;
    localparam logic [1:0] SRCB_IMM  = 2'd1;
    localparam logic [1:0] SRCB_FOUR = 2'd2;

    localparam logic [1:0] ALU_ADD   = 2'd0;
    localparam logic [1:0] ALU_SUB   = 2'd1;
    localparam logic [1:0] ALU_FUNCT = 2'd2;

    localparam logic [1:0] WB_ALU  = 2'd0;
    localparam logic [1:0] WB_MEM  = 2'd1;
    localparam logic [1:0] WB_LINK = 2'd2;

    function automatic logic is_known_op(input logic [6:0] op);
        case (op)
            OP_RTYPE, OP_IALU, OP_LUI, OP_AUIPC, OP_LOAD,
            OP_STORE, OP_BRANCH, OP_JAL, OP_JALR: is_known_op = 1'b1;
            default:                              is_known_op = 1'b0;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/branch_cond.sv
// ============================================================================
// Module : branch_cond
// Brief  : Branch outcome from funct3 and ALU rs1-rs2 flags.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_cond (
    input  logic [2:0] i_funct3,
    input  logic       i_zero,
    input  logic       i_lt,
    input  logic       i_ltu,
    output logic       o_taken,
    output logic       o_invalid
);

    always_comb begin
        o_taken   = 1'b0;
        o_invalid = 1'b0;
        case (i_funct3)
            3'b000:  o_taken = i_zero;
            3'b001:  o_taken = !i_zero;
            3'b100:  o_taken = i_lt;
            3'b101:  o_taken = !i_lt;
            3'b110:  o_taken = i_ltu;
            3'b111:  o_taken = !i_ltu;
            default: o_invalid = 1'b1;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/multicycle_ctrl.sv
// ============================================================================
// Module : multicycle_ctrl
// Brief  : RV32I multicycle control FSM (fetch/decode/exec/mem/wb/trap).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_ctrl
    import cpu_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic        alu_zero,
    input  logic        alu_lt,
    input  logic        alu_ltu,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        iord,
    output logic        ir_we,
    output logic        pc_we,
    output logic        reg_we,
    output logic        pc_src,
    output logic [2:0]  imm_sel,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_op,
    output logic [1:0]  wb_sel,
    output logic        illegal,
    output logic [31:0] instret
);

    state_t      r_state;
    logic [31:0] r_instret;
    state_t      w_next;
    logic        w_retire;
    logic        w_taken;
    logic        w_br_invalid;
    logic [2:0]  w_imm_sel;
    logic [1:0]  w_src_a;
    logic [1:0]  w_src_b;
    logic [1:0]  w_alu_op;
    logic        w_is_load;
    logic        w_is_store;
    logic        w_is_branch;
    logic        w_is_jump;

    branch_cond u_branch_cond (
        .i_funct3  (funct3),
        .i_zero    (alu_zero),
        .i_lt      (alu_lt),
        .i_ltu     (alu_ltu),
        .o_taken   (w_taken),
        .o_invalid (w_br_invalid)
    );

    assign w_is_load   = (opcode == OP_LOAD);
    assign w_is_store  = (opcode == OP_STORE);
    assign w_is_branch = (opcode == OP_BRANCH);
    assign w_is_jump   = (opcode == OP_JAL) || (opcode == OP_JALR);

    // Selects are held from EXEC through MEM/WB so the ALU result stays valid.
    always_comb begin
        w_imm_sel = IMM_I;
        w_src_a   = SRCA_RS1;
        w_src_b   = SRCB_IMM;
        w_alu_op  = ALU_ADD;
        case (opcode)
            OP_RTYPE:  begin w_src_b = SRCB_RS2; w_alu_op = ALU_FUNCT; end
            OP_IALU:   w_alu_op = ALU_FUNCT;
            OP_LUI:    begin w_imm_sel = IMM_U; w_src_a = SRCA_ZERO; end
            OP_AUIPC:  begin w_imm_sel = IMM_U; w_src_a = SRCA_PC; end
            OP_STORE:  w_imm_sel = IMM_S;
            OP_BRANCH: begin w_imm_sel = IMM_B; w_src_a = SRCA_PC; end
            OP_JAL:    begin w_imm_sel = IMM_J; w_src_a = SRCA_PC; end
            default:   ;
        endcase
    end

    always_comb begin
        w_next    = r_state;
        w_retire  = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        iord      = 1'b0;
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        reg_we    = 1'b0;
        pc_src    = 1'b0;
        imm_sel   = IMM_I;
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_RS2;
        alu_op    = ALU_ADD;
        wb_sel    = WB_ALU;
        illegal   = 1'b0;
        case (r_state)
            ST_FETCH: begin
                mem_req   = 1'b1;
                alu_src_a = SRCA_PC;
                alu_src_b = SRCB_FOUR;
                if (mem_ready) begin
                    ir_we  = 1'b1;
                    pc_we  = 1'b1;
                    w_next = ST_DECODE;
                end
            end
            ST_DECODE: begin
                w_next = is_known_op(opcode) ? ST_EXEC : ST_TRAP;
            end
            ST_EXEC: begin
                imm_sel   = w_imm_sel;
                alu_src_a = w_src_a;
                alu_src_b = w_src_b;
                alu_op    = w_alu_op;
                if (w_is_branch) begin
                    if (w_br_invalid) begin
                        w_next = ST_TRAP;
                    end else begin
                        pc_we    = w_taken;
                        pc_src   = w_taken;
                        w_retire = 1'b1;
                        w_next   = ST_FETCH;
                    end
                end else if (w_is_jump) begin
                    pc_we  = 1'b1;
                    pc_src = 1'b1;
                    w_next = ST_WB;
                end else if (w_is_load || w_is_store) begin
                    w_next = ST_MEM;
                end else begin
                    w_next = ST_WB;
                end
            end
            ST_MEM: begin
                imm_sel   = w_imm_sel;
                alu_src_a = w_src_a;
                alu_src_b = w_src_b;
                alu_op    = w_alu_op;
                mem_req   = 1'b1;
                iord      = 1'b1;
                mem_we    = w_is_store;
                if (mem_ready) begin
                    w_next   = w_is_store ? ST_FETCH : ST_WB;
                    w_retire = w_is_store;
                end
            end
            ST_WB: begin
                imm_sel   = w_imm_sel;
                alu_src_a = w_src_a;
                alu_src_b = w_src_b;
                alu_op    = w_alu_op;
                reg_we    = 1'b1;
                wb_sel    = w_is_load ? WB_MEM : (w_is_jump ? WB_LINK : WB_ALU);
                w_retire  = 1'b1;
                w_next    = ST_FETCH;
            end
            ST_TRAP: illegal = 1'b1;
            default: w_next = ST_FETCH;
        endcase
        // Reset must silence the bus instantly, not at the next edge.
        if (rst) begin
            w_retire  = 1'b0;
            mem_req   = 1'b0;
            mem_we    = 1'b0;
            iord      = 1'b0;
            ir_we     = 1'b0;
            pc_we     = 1'b0;
            reg_we    = 1'b0;
            pc_src    = 1'b0;
            imm_sel   = 3'd0;
            alu_src_a = 2'd0;
            alu_src_b = 2'd0;
            alu_op    = 2'd0;
            wb_sel    = 2'd0;
            illegal   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_FETCH;
            r_instret <= 32'd0;
        end else begin
            r_state <= w_next;
            if (w_retire) begin
                r_instret <= r_instret + 32'd1;
            end
        end
    end

    assign instret = r_instret;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
// ============================================================================
// Module : tb_multicycle_ctrl
// Brief  : Self-checking bench for multicycle_ctrl with a phase-timeline model.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multicycle_ctrl;

    localparam logic [6:0] C_R   = 7'b0110011;
    localparam logic [6:0] C_I   = 7'b0010011;
    localparam logic [6:0] C_LUI = 7'b0110111;
    localparam logic [6:0] C_AUI = 7'b0010111;
    localparam logic [6:0] C_LD  = 7'b0000011;
    localparam logic [6:0] C_ST  = 7'b0100011;
    localparam logic [6:0] C_BR  = 7'b1100011;
    localparam logic [6:0] C_JAL = 7'b1101111;
    localparam logic [6:0] C_JR  = 7'b1100111;

    typedef enum int {PH_F, PH_D, PH_E, PH_M, PH_W, PH_T} ph_t;

    logic        clk;
    logic        rst;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        alu_zero, alu_lt, alu_ltu, mem_ready;
    logic        mem_req, mem_we, iord, ir_we, pc_we, reg_we, pc_src, illegal;
    logic [2:0]  imm_sel;
    logic [1:0]  alu_src_a, alu_src_b, alu_op, wb_sel;
    logic [31:0] instret;
    logic [18:0] w_all;

    int n_cmp;
    int n_fail;
    int exp_ret;

    multicycle_ctrl u_dut (
        .clk       (clk),
        .rst       (rst),
        .opcode    (opcode),
        .funct3    (funct3),
        .alu_zero  (alu_zero),
        .alu_lt    (alu_lt),
        .alu_ltu   (alu_ltu),
        .mem_ready (mem_ready),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .iord      (iord),
        .ir_we     (ir_we),
        .pc_we     (pc_we),
        .reg_we    (reg_we),
        .pc_src    (pc_src),
        .imm_sel   (imm_sel),
        .alu_src_a (alu_src_a),
        .alu_src_b (alu_src_b),
        .alu_op    (alu_op),
        .wb_sel    (wb_sel),
        .illegal   (illegal),
        .instret   (instret)
    );

    assign w_all = {mem_req, mem_we, iord, ir_we, pc_we, reg_we, pc_src,
                    imm_sel, alu_src_a, alu_src_b, alu_op, wb_sel, illegal};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, required finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    function automatic logic branch_taken(input logic [2:0] f3, input logic [2:0] fl);
        case (f3)
            3'b000:  branch_taken = fl[2];
            3'b001:  branch_taken = !fl[2];
            3'b100:  branch_taken = fl[1];
            3'b101:  branch_taken = !fl[1];
            3'b110:  branch_taken = fl[0];
            default: branch_taken = !fl[0];
        endcase
    endfunction

    // Expected per-cycle phase list for one instruction, then a cycle-by-cycle check.
    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic [2:0] fl,
                             input int wf, input int wm, input int trap_cycles);
        ph_t  ph[$];
        logic rdy[$];
        logic known, br, ld, st, jal, jr, bad, tk, retire;
        logic [6:0] v_exp;
        logic [2:0] imm_exp;
        logic [1:0] a_exp;
        known = (op == C_R) || (op == C_I) || (op == C_LUI) || (op == C_AUI) || (op == C_LD) ||
                (op == C_ST) || (op == C_BR) || (op == C_JAL) || (op == C_JR);
        br  = (op == C_BR);
        ld  = (op == C_LD);
        st  = (op == C_ST);
        jal = (op == C_JAL);
        jr  = (op == C_JR);
        bad = br && (f3 == 3'b010 || f3 == 3'b011);
        tk  = br && !bad && branch_taken(f3, fl);
        for (int i = 0; i <= wf; i++) begin ph.push_back(PH_F); rdy.push_back(i == wf); end
        ph.push_back(PH_D); rdy.push_back(1'b0);
        if (!known) begin
            for (int i = 0; i < trap_cycles; i++) begin ph.push_back(PH_T); rdy.push_back(1'b0); end
        end else begin
            ph.push_back(PH_E); rdy.push_back(1'b0);
            if (bad) begin
                for (int i = 0; i < trap_cycles; i++) begin ph.push_back(PH_T); rdy.push_back(1'b0); end
            end else begin
                if (ld || st) begin
                    for (int i = 0; i <= wm; i++) begin ph.push_back(PH_M); rdy.push_back(i == wm); end
                end
                if (!br && !st) begin ph.push_back(PH_W); rdy.push_back(1'b0); end
            end
        end
        retire = known && !bad;
        imm_exp = st ? 3'd1 : br ? 3'd2 : (op == C_LUI || op == C_AUI) ? 3'd3 : jal ? 3'd4 : 3'd0;
        a_exp   = (op == C_LUI) ? 2'd2 : (op == C_AUI || br || jal) ? 2'd1 : 2'd0;
        opcode   = op;
        funct3   = f3;
        alu_zero = fl[2];
        alu_lt   = fl[1];
        alu_ltu  = fl[0];
        for (int c = 0; c < ph.size(); c++) begin
            if (ph[c] == PH_F || ph[c] == PH_M) mem_ready = rdy[c];
            else                                mem_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            // {mem_req, iord, mem_we, ir_we, pc_we, reg_we, illegal}
            case (ph[c])
                PH_F:    v_exp = {1'b1, 1'b0, 1'b0, rdy[c], rdy[c], 1'b0, 1'b0};
                PH_D:    v_exp = 7'b0;
                PH_E:    v_exp = {4'b0, (tk || jal || jr), 2'b0};
                PH_M:    v_exp = {1'b1, 1'b1, st, 4'b0};
                PH_W:    v_exp = 7'b0000010;
                default: v_exp = 7'b0000001;
            endcase
            check($sformatf("strobes op=%h ph=%0d c=%0d", op, ph[c], c),
                  32'({mem_req, iord, mem_we, ir_we, pc_we, reg_we, illegal}), 32'(v_exp));
            check("instret", instret, 32'(exp_ret));
            if (v_exp[2]) check("pc_src", 32'(pc_src), (ph[c] == PH_F) ? 32'd0 : 32'd1);
            if (ph[c] == PH_E && op != C_R) check("imm_sel", 32'(imm_sel), 32'(imm_exp));
            if (ph[c] == PH_E) begin
                check("alu_src_a", 32'(alu_src_a), 32'(a_exp));
                check("alu_src_b", 32'(alu_src_b), (op == C_R) ? 32'd0 : 32'd1);
                if (op == C_R || op == C_I) check("alu_op", 32'(alu_op), 32'd2);
            end
            if (ph[c] == PH_W) check("wb_sel", 32'(wb_sel), ld ? 32'd1 : (jal || jr) ? 32'd2 : 32'd0);
            @(posedge clk);
            #1;
        end
        if (retire) exp_ret++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("reset outputs", 32'(w_all), 32'd0);
        check("reset instret", instret, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_ret = 0;
    endtask

    initial begin
        logic [6:0] ops [9];
        logic [2:0] brf [6];
        logic [2:0] f3r;
        int k;
        ops = '{C_R, C_I, C_LUI, C_AUI, C_LD, C_ST, C_BR, C_JAL, C_JR};
        brf = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111};
        n_cmp = 0; n_fail = 0; exp_ret = 0;
        rst = 1'b1; opcode = '0; funct3 = '0; mem_ready = 1'b1;
        alu_zero = 1'b0; alu_lt = 1'b0; alu_ltu = 1'b0;
        #2;
        check("reset outputs", 32'(w_all), 32'd0);
        check("reset instret", instret, 32'd0);
        @(posedge clk); #1; rst = 1'b0;

        run_instr(C_R,   3'b000, 3'b000, 0, 0, 0);   // ADD x3,x1,x2
        run_instr(C_LD,  3'b010, 3'b000, 0, 3, 0);   // LW, 3 wait cycles in MEM
        run_instr(C_BR,  3'b000, 3'b100, 0, 0, 0);   // BEQ taken
        run_instr(C_BR,  3'b000, 3'b000, 0, 0, 0);   // BEQ not taken
        run_instr(C_ST,  3'b010, 3'b000, 2, 1, 0);
        run_instr(C_JAL, 3'b000, 3'b000, 0, 0, 0);
        run_instr(C_JR,  3'b000, 3'b000, 1, 0, 0);
        run_instr(C_LUI, 3'b000, 3'b000, 0, 0, 0);
        run_instr(C_AUI, 3'b000, 3'b000, 0, 0, 0);
        run_instr(C_I,   3'b000, 3'b000, 0, 0, 0);

        run_instr(7'h7F, 3'b000, 3'b000, 0, 0, 10);
        do_reset();
        run_instr(C_BR,  3'b010, 3'b111, 1, 0, 10);
        do_reset();

        for (int n = 0; n < 40; n++) begin
            k = $urandom_range(0, 8);
            f3r = (ops[k] == C_BR) ? brf[$urandom_range(0, 5)] : 3'($urandom_range(0, 7));
            run_instr(ops[k], f3r, 3'($urandom_range(0, 7)),
                      $urandom_range(0, 2), $urandom_range(0, 2), 0);
        end

        // Asynchronous reset in the middle of a stalled fetch.
        opcode = C_R; mem_ready = 1'b0;
        @(negedge clk);
        check("fetch mem_req before reset", 32'(mem_req), 32'd1);
        #1; rst = 1'b1;
        #1;
        check("async mem_req drop", 32'(mem_req), 32'd0);
        check("async instret clear", instret, 32'd0);
        check("async all outputs", 32'(w_all), 32'd0);
        exp_ret = 0;
        @(posedge clk); #1; rst = 1'b0;
        run_instr(C_R, 3'b000, 3'b000, 1, 0, 0);
        check("instret after restart", instret, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
